// File: rtl/sender_burst_pkg.sv
// Shared types and defaults for the burst sender.
package sender_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 16;

    // CHK is only reachable when SENDER_BURST_CHECKSUM_EN is defined.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_LOW = 2'd2,
        CHK      = 2'd3
    } state_t;

    // Reset content of buffer entry i: its own index.
    // DEPTH never exceeds 256, so 8 bits always hold the index.
    function automatic logic [7:0] init_word(input int i);
        return i[7:0];
    endfunction

endpackage

// File: rtl/sender_burst_if.sv
// Producer / receiver side signals of the burst sender.
interface sender_burst_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic             write;
    logic [WIDTH-1:0] data;
    logic             start;
    logic [AW:0]      len;
    logic             Ack;
    logic             Request;
    logic [WIDTH-1:0] sdrDataOut;
    logic             busy;
    logic             done;
    logic             wr_drop;

    // master: producer and receiver environment; slave: the sender itself
    modport master (
        output write, data, start, len, Ack,
        input  Request, sdrDataOut, busy, done, wr_drop
    );
    modport slave (
        input  write, data, start, len, Ack,
        output Request, sdrDataOut, busy, done, wr_drop
    );
endinterface

// File: rtl/sender_burst_buf.sv
// DEPTH x WIDTH word buffer: circular write pointer, index-valued reset
// content, combinational read port.
module sender_buf
    import sender_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     Reset,
    input  logic                     we,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH)-1:0] wptr
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    // Reset reloads every entry; otherwise append at the write pointer and wrap.
    always_ff @(posedge clk) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= WIDTH'(init_word(i));
            wptr <= '0;
        end else if (we) begin
            mem[wptr] <= wdata;
            wptr      <= wptr + AW'(1);
        end
    end

    assign rdata = mem[rd_addr];

endmodule

// File: rtl/sender_burst.sv
// Burst sender: buffered words go out over a 4-phase Request/Ack handshake.
// Optional feature macro: SENDER_BURST_CHECKSUM_EN appends an XOR checksum
// word to every burst.
module sender_burst
    import sender_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic          clk,
    input  logic          Reset,
    sender_burst_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    state_t           state;
    logic [AW-1:0]    raddr;
    logic [AW-1:0]    rd_addr;
    logic [AW-1:0]    wptr;
    logic [AW:0]      cnt;
    logic [AW:0]      len_eff;
    logic [WIDTH-1:0] rdata;
    logic [WIDTH-1:0] first_word;
    logic             wr_ok;
`ifdef SENDER_BURST_CHECKSUM_EN
    logic [WIDTH-1:0] chk;
    logic             chk_sent;
`endif

    assign wr_ok = bus.write && !bus.busy;

    // Idle reads sit on entry 0 so the first word is ready when start lands.
    assign rd_addr = (state == IDLE) ? '0 : raddr;

    // A write to entry 0 in the start cycle must reach the first word.
    assign first_word = (wr_ok && wptr == '0) ? bus.data : rdata;

    // 0 and anything above DEPTH both mean a full-buffer burst.
    always_comb begin
        len_eff = bus.len;
        if (bus.len == '0 || bus.len > (AW+1)'(DEPTH)) len_eff = (AW+1)'(DEPTH);
    end

    sender_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_buf (
        .clk     (clk),
        .Reset   (Reset),
        .we      (wr_ok),
        .wdata   (bus.data),
        .rd_addr (rd_addr),
        .rdata   (rdata),
        .wptr    (wptr)
    );

    // Handshake FSM with registered Request/data/status outputs.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state          <= IDLE;
            raddr          <= '0;
            cnt            <= '0;
            bus.Request    <= 1'b0;
            bus.sdrDataOut <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.wr_drop    <= 1'b0;
`ifdef SENDER_BURST_CHECKSUM_EN
            chk            <= '0;
            chk_sent       <= 1'b0;
`endif
        end else begin
            bus.done    <= 1'b0;
            bus.wr_drop <= bus.write && bus.busy;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        cnt            <= len_eff;
                        raddr          <= '0;
                        bus.Request    <= 1'b1;
                        bus.sdrDataOut <= first_word;
                        bus.busy       <= 1'b1;
                        state          <= REQ;
`ifdef SENDER_BURST_CHECKSUM_EN
                        chk            <= first_word;
                        chk_sent       <= 1'b0;
`endif
                    end
                end
                REQ: begin
                    if (bus.Ack) begin
                        bus.Request <= 1'b0;
                        raddr       <= raddr + AW'(1);
                        cnt         <= cnt - (AW+1)'(1);
                        state       <= WAIT_LOW;
                    end
                end
                WAIT_LOW: begin
                    if (!bus.Ack) begin
                        if (cnt != '0) begin
                            bus.Request    <= 1'b1;
                            bus.sdrDataOut <= rdata;
                            state          <= REQ;
`ifdef SENDER_BURST_CHECKSUM_EN
                            chk            <= chk ^ rdata;
                        end else if (!chk_sent) begin
                            bus.Request    <= 1'b1;
                            bus.sdrDataOut <= chk;
                            state          <= CHK;
`endif
                        end else begin
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                end
`ifdef SENDER_BURST_CHECKSUM_EN
                CHK: begin
                    if (bus.Ack) begin
                        bus.Request <= 1'b0;
                        chk_sent    <= 1'b1;
                        state       <= WAIT_LOW;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
